if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage of the RV32I pipeline.
- Captures the {PC, PC+4, instruction} triple from fetch into a small circular queue and presents the oldest entry to decode with a valid/ready handshake.
- Its not-full signal stalls the PC when decode backs up.
- Flush discards all buffered fetches on a taken branch or jump.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- PTR_W, log2(DEPTH), width of the read/write pointers; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  kill all entries; asserted by execute on a taken branch or jump.
- if_valid  in  1  fetch presents a valid triple this cycle.
- if_ready  out  1  queue can accept a triple; drives the PC write-enable.
- PC_IF  in  32  PC of the fetched instruction.
- PC_4_IF  in  32  PC+4 of the fetched instruction.
- INSTRUCTION_IF  in  32  fetched instruction word.
- id_valid  out  1  head entry valid.
- id_ready  in  1  decode consumes the head this cycle.
- PC_ID  out  32  PC of the head entry.
- PC_4_ID  out  32  PC+4 of the head entry.
- INSTRUCTION_ID  out  32  instruction word of the head entry.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, rst=1), effective immediately:
  - wr_ptr, rd_ptr and count are 0; id_valid=0; if_ready=1.
  - PC_ID=0, PC_4_ID=0, INSTRUCTION_ID=NOP (32'h00000013).
  - Storage contents are don't-care.
- Handshakes:
  - push = if_valid & if_ready; pop = id_valid & id_ready.
  - if_ready = (count != DEPTH). It is a pure function of registered state, with no combinational path from id_ready.
  - id_valid = (count != 0), also from registered state only.
- Latency: a triple pushed in cycle N is visible at the outputs in cycle N+1 (minimum one cycle). There is no same-cycle bypass from input to output.
- Outputs:
  - When count != 0, the PC_ID, PC_4_ID and INSTRUCTION_ID outputs come from the entry at rd_ptr.
  - When count == 0 they are forced to 0, 0 and NOP, so decode sees a bubble.
- Pointer rules:
  - push writes the entry at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH.
  - pop does rd_ptr = rd_ptr+1 mod DEPTH.
  - Count update: push only, +1; pop only, -1; push and pop together, unchanged (only possible when 0 < count < DEPTH).
- Occupancy states, as implied by count:
  - EMPTY (count=0): only push can occur.
  - PARTIAL: push, pop or both can occur.
  - FULL (count=DEPTH): if_ready=0, so an input presented while full is not captured; fetch must hold it.
- Full with pop: in that cycle only the pop takes effect, and if_ready rises in the next cycle.
- Flush (synchronous, highest priority):
  - On the clock edge with flush=1: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in that same cycle is discarded and the storage write is suppressed.
  - In the next cycle id_valid=0, outputs show NOP, if_ready=1.
  - Held flush: every cycle it is high the queue stays empty.
- Reset mid-operation: all in-flight entries are lost, with the same state as after power-up reset.
- Widths: all data paths are 32-bit. Pointers wrap naturally because DEPTH is a power of two.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN = 32.
  - RV_NOP = 32'h00000013 (addi x0,x0,0).
  - A packed fetch-bundle typedef {pc, pc4, instr} of 96 bits, stored as one word per entry.
- No sub-module. Storage is a DEPTH-entry flop array inside the block, because the asynchronous-reset control and the forced-NOP mux are cheaper written inline.

Test Plan:
- Reset while pushing:
  - Stimulus: assert rst for 2 cycles while if_valid=1.
  - Required: id_valid=0, INSTRUCTION_ID=32'h00000013, if_ready=1, count=0; nothing captured.
- Single push, then pop:
  - Stimulus: push PC=0x0, PC+4=0x4, INSTR=0x00500093 with id_ready=0.
  - Required next cycle: id_valid=1, PC_ID=0x0, count=1.
  - Then raise id_ready for one cycle; required next cycle: id_valid=0, count=0.
- Fill and backpressure (DEPTH=2):
  - Stimulus: push PC 0x0 and 0x4 with id_ready=0.
  - Required: count=2, if_ready=0; a third triple with PC=0x8 held on the inputs is not captured.
  - Then pop once; required: PC_ID becomes 0x4, if_ready=1, after which 0x8 is accepted.
- Streaming:
  - Stimulus: if_valid=1 and id_ready=1 continuously over PCs 0x0, 0x4, ..., 0x3C.
  - Required: after the 1-cycle fill, one pop per cycle, in order, with no gaps or duplicates, and count stays 1.
- Flush with simultaneous push and pop:
  - Stimulus: count=2 with entries 0x10 and 0x14; flush=1 in the same cycle as push of 0x18 and pop.
  - Required next cycle: count=0, id_valid=0, INSTRUCTION_ID=NOP.
  - Then push 0x40; required: it appears at PC_ID in the following cycle.
- Pointer wrap:
  - Stimulus: 5 push/pop pairs at DEPTH=2.
  - Required: PC_ID order matches the push order, with correct data across the pointer wrap.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: data width, canonical NOP and the
// fetch bundle carried from fetch to decode.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  // One queue entry: {pc, pc+4, instruction}, 96 bits.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } fetch_bundle_t;

endpackage : rv32i_pkg

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular buffer between fetch and
// decode with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    discard all entries (taken branch/jump)
//   if_valid / if_ready      fetch-side handshake; if_ready gates PC write
//   PC_IF, PC_4_IF,
//   INSTRUCTION_IF           fetched triple
//   id_valid / id_ready      decode-side handshake
//   PC_ID, PC_4_ID,
//   INSTRUCTION_ID           head entry, or {0, 0, NOP} when empty
//   count                    occupancy, 0..DEPTH
module if_id_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  PC_IF,
  input  logic [XLEN-1:0]  PC_4_IF,
  input  logic [XLEN-1:0]  INSTRUCTION_IF,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  PC_ID,
  output logic [XLEN-1:0]  PC_4_ID,
  output logic [XLEN-1:0]  INSTRUCTION_ID,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  fetch_bundle_t    mem_q [DEPTH];
  fetch_bundle_t    mem_d [DEPTH];

  logic push_c;
  logic pop_c;
  fetch_bundle_t head_c;

  // Handshake status depends only on registered occupancy.
  assign if_ready = (count_q != FULL_CNT);
  assign id_valid = (count_q != '0);
  assign count    = count_q;

  assign push_c = if_valid & if_ready;
  assign pop_c  = id_valid & id_ready;

  // Next-state: flush overrides any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = '{pc: PC_IF, pc4: PC_4_IF, instr: INSTRUCTION_IF};
        wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop_c) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      case ({push_c, pop_c})
        2'b10:   count_d = (PTR_W+1)'(count_q + (PTR_W+1)'(1));
        2'b01:   count_d = (PTR_W+1)'(count_q - (PTR_W+1)'(1));
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Empty queue presents a bubble so decode never sees stale data.
  always_comb begin
    head_c = '{pc: '0, pc4: '0, instr: RV_NOP};
    if (count_q != '0) begin
      head_c = mem_q[rd_ptr_q];
    end
  end

  assign PC_ID          = head_c.pc;
  assign PC_4_ID        = head_c.pc4;
  assign INSTRUCTION_ID = head_c.instr;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_if_id_queue;
  import rv32i_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             if_valid;
  logic             if_ready;
  logic [XLEN-1:0]  PC_IF, PC_4_IF, INSTRUCTION_IF;
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  PC_ID, PC_4_ID, INSTRUCTION_ID;
  logic [PTR_W:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_bundle_t model_q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .PC_IF         (PC_IF),
    .PC_4_IF       (PC_4_IF),
    .INSTRUCTION_IF(INSTRUCTION_IF),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .PC_ID         (PC_ID),
    .PC_4_ID       (PC_4_ID),
    .INSTRUCTION_ID(INSTRUCTION_ID),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output with what the model says decode should see.
  task automatic check_outputs();
    int n = model_q.size();
    check("id_valid", 32'(id_valid), 32'(n != 0));
    check("if_ready", 32'(if_ready), 32'(n != DEPTH));
    check("count",    32'(count),    32'(n));
    check("PC_ID",    PC_ID,          (n != 0) ? model_q[0].pc    : 32'h0);
    check("PC_4_ID",  PC_4_ID,        (n != 0) ? model_q[0].pc4   : 32'h0);
    check("INSTR_ID", INSTRUCTION_ID, (n != 0) ? model_q[0].instr : RV_NOP);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic rdy, input logic fl, input logic r);
    if_valid       = v;
    PC_IF          = pc;
    PC_4_IF        = pc + 32'd4;
    INSTRUCTION_IF = instr;
    id_ready       = rdy;
    flush          = fl;
    rst            = r;
  endtask

  // Advance one clock with the currently driven inputs and check results.
  task automatic cycle();
    bit do_push, do_pop;
    if (rst) begin
      model_q.delete();
      #1 check_outputs();
    end
    do_push = if_valid && (model_q.size() < DEPTH);
    do_pop  = id_ready && (model_q.size() > 0);
    @(posedge clk);
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: PC_IF, pc4: PC_4_IF, instr: INSTRUCTION_IF});
    end
    #1 check_outputs();
  endtask

  initial begin
    drive(1'b1, 32'h100, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    model_q.delete();
    #1 check_outputs();

    // Reset while fetch is pushing: nothing captured.
    cycle();
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("rst_cnt", 32'(count), 32'h0);

    // Single push then pop.
    drive(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    cycle();
    check("single_pc", PC_ID, 32'h0);
    check("single_ins", INSTRUCTION_ID, 32'h0050_0093);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("single_empty", 32'(id_valid), 32'h0);

    // Fill to DEPTH, hold a third triple under backpressure, then drain one.
    drive(1'b1, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h4, 32'hA4, 1'b0, 1'b0, 1'b0); cycle();
    check("full_ready", 32'(if_ready), 32'h0);
    drive(1'b1, 32'h8, 32'hA8, 1'b0, 1'b0, 1'b0); cycle(); cycle();
    check("full_hold_pc", PC_ID, 32'h0);
    drive(1'b1, 32'h8, 32'hA8, 1'b1, 1'b0, 1'b0); cycle();
    check("full_pop_pc", PC_ID, 32'h4);
    check("full_pop_rdy", 32'(if_ready), 32'h1);
    drive(1'b1, 32'h8, 32'hA8, 1'b0, 1'b0, 1'b0); cycle();
    check("full_accept", 32'(count), 32'h2);

    // Drain and stream 0x0..0x3C.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cycle(); cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
      cycle();
      check("stream_pc", PC_ID, 32'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();

    // Flush with simultaneous push and pop.
    drive(1'b1, 32'h10, 32'hB0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h14, 32'hB4, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h18, 32'hB8, 1'b1, 1'b1, 1'b0); cycle();
    check("flush_ins", INSTRUCTION_ID, RV_NOP);
    drive(1'b1, 32'h40, 32'hC0, 1'b0, 1'b0, 1'b0); cycle();
    check("flush_after_pc", PC_ID, 32'h40);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();

    // Pointer wrap: push/pop pairs.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 32'hD0 + 32'(i), 1'b0, 1'b0, 1'b0); cycle();
      check("wrap_pc", PC_ID, 32'h200 + 32'(i * 4));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cycle();
    end

    // Random traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 199) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_if_id_queue
